// File: rtl/spi_link_pkg.sv
// Shared SPI link definitions: frame layout and the responder FSM encoding.
// Used by both the response side and the request-side master.
package spi_link_pkg;

    localparam int FRAME_BITS = 16;
    localparam int SIN_BITS   = 12;
    localparam int ID_BITS    = 4;
    localparam int CNT_BITS   = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } link_state_e;

endpackage

// File: rtl/spi_respond_data_if.sv
// SPI bus bundle between the master and the data responder.
interface spi_respond_data_if;

    logic spi_clk;
    logic cs_n;
    logic mosi;
    logic miso;

    modport master (output spi_clk, output cs_n, output mosi, input miso);
    modport slave  (input spi_clk, input cs_n, input mosi, output miso);

endinterface

// File: rtl/spi_sync.sv
// Multi-stage synchronizer with one extra register for rise/fall edge detection.
// IDLE_LEVEL is the value the chain assumes under reset.
module spi_sync #(
    parameter int   STAGES     = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              last;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= {STAGES{IDLE_LEVEL}};
            last  <= IDLE_LEVEL;
        end else begin
            chain <= (chain << 1) | STAGES'(d);
            last  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~last;
    assign fall = ~q & last;

endmodule

// File: rtl/spi_respond_data.sv
// SPI mode-0 responder sending {sin_index, uart_id} MSB first from a shadow register.
// Optional SPI_RESPOND_RX_CMD_EN adds a mosi receive register with cmd_word/cmd_valid.
module spi_respond_data
    import spi_link_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_respond_data_if.slave     bus,
    input  logic                  load,
    input  logic [SIN_BITS-1:0]   sin_index,
    input  logic [ID_BITS-1:0]    uart_id,
    output logic                  frame_done,
    output logic                  frame_error,
    output logic                  stale
`ifdef SPI_RESPOND_RX_CMD_EN
    ,
    output logic [FRAME_BITS-1:0] cmd_word,
    output logic                  cmd_valid
`endif
);

    localparam logic [CNT_BITS-1:0] FULL = CNT_BITS'(FRAME_BITS);

    link_state_e           state;
    logic [FRAME_BITS-1:0] shadow;
    logic [FRAME_BITS-1:0] shreg;
    logic [CNT_BITS-1:0]   cnt;
    logic                  miso_q;
    logic                  sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic                  unused_sclk_lvl, unused_cs_lvl;
    logic                  cnt_full;

    spi_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(bus.spi_clk),
        .q(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .d(bus.cs_n),
        .q(unused_cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    assign cnt_full = (cnt == FULL);
    assign bus.miso = miso_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shadow      <= '0;
            shreg       <= '0;
            cnt         <= '0;
            miso_q      <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            stale       <= 1'b1;
        end else begin
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            if (load) begin
                shadow <= {sin_index, uart_id};
                stale  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (cs_fall) begin
                        shreg  <= shadow;
                        miso_q <= shadow[FRAME_BITS-1];
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        miso_q <= 1'b0;
                        state  <= FINISH;
                    end else begin
                        if (sclk_rise && !cnt_full)
                            cnt <= cnt + 1'b1;
                        // Past bit 0 the line is held low for any extra clocks.
                        if (sclk_fall) begin
                            if (!cnt_full) begin
                                shreg  <= shreg << 1;
                                miso_q <= shreg[FRAME_BITS-2];
                            end else begin
                                miso_q <= 1'b0;
                            end
                        end
                    end
                end
                FINISH: begin
                    miso_q <= 1'b0;
                    state  <= IDLE;
                    if (cnt_full) begin
                        frame_done <= 1'b1;
                        if (!load)
                            stale <= 1'b1;
                    end else begin
                        frame_error <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_RESPOND_RX_CMD_EN
    logic                  mosi_lvl;
    logic                  unused_mosi_rise, unused_mosi_fall;
    logic [FRAME_BITS-1:0] rx_reg;

    spi_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .d(bus.mosi),
        .q(mosi_lvl), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    // mosi shares the spi_clk synchronizer depth, so both are aligned here.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_reg    <= '0;
            cmd_word  <= '0;
            cmd_valid <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            if (state == SHIFT && !cs_rise && sclk_rise && !cnt_full)
                rx_reg <= {rx_reg[FRAME_BITS-2:0], mosi_lvl};
            if (state == FINISH && cnt_full) begin
                cmd_word  <= rx_reg;
                cmd_valid <= 1'b1;
            end
        end
    end
`else
    logic unused_mosi;
    assign unused_mosi = bus.mosi;
`endif

endmodule

// File: tb/tb_spi_respond_data.sv
// Self-checking bench for spi_respond_data: bus-level SPI master plus shadow/stale model.
module tb_spi_respond_data;

    localparam int H = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [11:0] sin_index = '0;
    logic [3:0]  uart_id = '0;
    logic        frame_done, frame_error, stale;
`ifdef SPI_RESPOND_RX_CMD_EN
    logic [15:0] cmd_word;
    logic        cmd_valid;
`endif

    spi_respond_data_if bus();

    spi_respond_data dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .load(load),
        .sin_index(sin_index), .uart_id(uart_id),
        .frame_done(frame_done), .frame_error(frame_error), .stale(stale)
`ifdef SPI_RESPOND_RX_CMD_EN
        , .cmd_word(cmd_word), .cmd_valid(cmd_valid)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0, err_seen = 0, cv_seen = 0, cv_bad = 0;

    logic [15:0] m_shadow;
    logic        m_stale;

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_seen++;
        if (frame_error === 1'b1) err_seen++;
`ifdef SPI_RESPOND_RX_CMD_EN
        if (cmd_valid === 1'b1) cv_seen++;
        if (cmd_valid !== frame_done) cv_bad++;
`endif
    end

    task automatic do_load(input logic [15:0] v);
        @(negedge clk);
        sin_index = v[15:4];
        uart_id   = v[3:0];
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
        m_shadow  = v;
        m_stale   = 1'b0;
    endtask

    // One master transaction; optional load pulse just after rising edge number load_bit.
    task automatic spi_xfer(input int nbits, input logic [31:0] tx, input int load_bit,
                            input logic [15:0] load_val, input bit release_cs,
                            output logic [31:0] rx);
        rx = '0;
        @(negedge clk);
        bus.cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = tx[nbits-1-i];
            repeat (H) @(negedge clk);
            rx = {rx[30:0], bus.miso};
            bus.spi_clk = 1'b1;
            if (i == load_bit) begin
                sin_index = load_val[15:4];
                uart_id   = load_val[3:0];
                load      = 1'b1;
                @(negedge clk);
                load      = 1'b0;
                m_shadow  = load_val;
                m_stale   = 1'b0;
                repeat (H-1) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            bus.spi_clk = 1'b0;
        end
        if (release_cs) begin
            repeat (H) @(negedge clk);
            bus.cs_n = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        n_cmp++; if (bus.miso !== 1'b0) begin n_bad++; $display("FAIL reset_miso: got %b want 0", bus.miso); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", frame_done); end
        n_cmp++; if (frame_error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", frame_error); end
        n_cmp++; if (stale !== 1'b1) begin n_bad++; $display("FAIL reset_stale: got %b want 1", stale); end
        reset = 1'b0;
        m_shadow = '0;
        m_stale  = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (stale !== 1'b1) begin n_bad++; $display("FAIL post_reset_stale: got %b want 1", stale); end
    endtask

    task automatic test_no_load();
        logic [31:0] rx;
        int d0 = done_seen, e0 = err_seen;
        spi_xfer(16, 32'h0, -1, 16'h0, 1'b1, rx);
        m_stale = 1'b1;
        n_cmp++; if (rx[15:0] !== 16'h0000) begin n_bad++; $display("FAIL noload_data: got %h want 0000", rx[15:0]); end
        n_cmp++; if (done_seen - d0 !== 1) begin n_bad++; $display("FAIL noload_done: got %0d want 1", done_seen - d0); end
        n_cmp++; if (err_seen - e0 !== 0) begin n_bad++; $display("FAIL noload_err: got %0d want 0", err_seen - e0); end
        n_cmp++; if (stale !== 1'b1) begin n_bad++; $display("FAIL noload_stale: got %b want 1", stale); end
    endtask

    task automatic test_load_basic();
        logic [31:0] rx;
        int d0;
        do_load(16'hABC5);
        n_cmp++; if (stale !== 1'b0) begin n_bad++; $display("FAIL load_stale_clear: got %b want 0", stale); end
        d0 = done_seen;
        spi_xfer(16, 32'h0, -1, 16'h0, 1'b1, rx);
        m_stale = 1'b1;
        n_cmp++; if (rx[15:8] !== 8'hAB) begin n_bad++; $display("FAIL load_byte0: got %h want ab", rx[15:8]); end
        n_cmp++; if (rx[7:0] !== 8'hC5) begin n_bad++; $display("FAIL load_byte1: got %h want c5", rx[7:0]); end
        n_cmp++; if (done_seen - d0 !== 1) begin n_bad++; $display("FAIL load_done: got %0d want 1", done_seen - d0); end
        n_cmp++; if (stale !== 1'b1) begin n_bad++; $display("FAIL load_stale_set: got %b want 1", stale); end
    endtask

    task automatic test_midframe_load();
        logic [31:0] rx;
        logic [15:0] exp;
        do_load(16'h1234);
        exp = m_shadow;
        spi_xfer(16, 32'h0, 5, 16'hFFFF, 1'b1, rx);
        m_stale = 1'b1;
        n_cmp++; if (rx[15:0] !== exp) begin n_bad++; $display("FAIL midload_cur: got %h want %h", rx[15:0], exp); end
        exp = m_shadow;
        spi_xfer(16, 32'h0, -1, 16'h0, 1'b1, rx);
        n_cmp++; if (rx[15:0] !== exp) begin n_bad++; $display("FAIL midload_next: got %h want %h", rx[15:0], exp); end
    endtask

    task automatic test_abort();
        logic [31:0] rx;
        int d0, e0;
        do_load(16'($urandom));
        d0 = done_seen; e0 = err_seen;
        spi_xfer(9, 32'h0, -1, 16'h0, 1'b1, rx);
        n_cmp++; if (err_seen - e0 !== 1) begin n_bad++; $display("FAIL abort_err: got %0d want 1", err_seen - e0); end
        n_cmp++; if (done_seen - d0 !== 0) begin n_bad++; $display("FAIL abort_done: got %0d want 0", done_seen - d0); end
        n_cmp++; if (stale !== m_stale) begin n_bad++; $display("FAIL abort_stale: got %b want %b", stale, m_stale); end
        spi_xfer(16, 32'h0, -1, 16'h0, 1'b1, rx);
        m_stale = 1'b1;
        n_cmp++; if (rx[15:0] !== m_shadow) begin n_bad++; $display("FAIL abort_retry: got %h want %h", rx[15:0], m_shadow); end
    endtask

    task automatic test_overrun();
        logic [31:0] rx;
        int d0;
        do_load(16'($urandom));
        d0 = done_seen;
        spi_xfer(20, 32'h0, -1, 16'h0, 1'b1, rx);
        m_stale = 1'b1;
        n_cmp++; if (rx[19:0] !== {m_shadow, 4'h0}) begin n_bad++; $display("FAIL overrun_data: got %h want %h", rx[19:0], {m_shadow, 4'h0}); end
        n_cmp++; if (done_seen - d0 !== 1) begin n_bad++; $display("FAIL overrun_done: got %0d want 1", done_seen - d0); end
    endtask

    task automatic test_random();
        logic [31:0] rx;
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 3) != 0) do_load(16'($urandom));
            spi_xfer(16, 32'($urandom), -1, 16'h0, 1'b1, rx);
            m_stale = 1'b1;
            n_cmp++; if (rx[15:0] !== m_shadow) begin n_bad++; $display("FAIL rand_data[%0d]: got %h want %h", k, rx[15:0], m_shadow); end
            n_cmp++; if (stale !== m_stale) begin n_bad++; $display("FAIL rand_stale[%0d]: got %b want %b", k, stale, m_stale); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rx;
        int d0, e0;
        do_load(16'($urandom));
        spi_xfer(7, 32'h0, -1, 16'h0, 1'b0, rx);
        d0 = done_seen; e0 = err_seen;
        reset = 1'b1;
        bus.cs_n = 1'b1;
        bus.spi_clk = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_shadow = '0;
        m_stale  = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++; if (bus.miso !== 1'b0) begin n_bad++; $display("FAIL rstmid_miso: got %b want 0", bus.miso); end
        n_cmp++; if ((done_seen - d0) + (err_seen - e0) !== 0) begin n_bad++; $display("FAIL rstmid_pulses: got %0d want 0", (done_seen - d0) + (err_seen - e0)); end
        n_cmp++; if (stale !== 1'b1) begin n_bad++; $display("FAIL rstmid_stale: got %b want 1", stale); end
        spi_xfer(16, 32'h0, -1, 16'h0, 1'b1, rx);
        n_cmp++; if (rx[15:0] !== 16'h0000) begin n_bad++; $display("FAIL rstmid_next: got %h want 0000", rx[15:0]); end
    endtask

`ifdef SPI_RESPOND_RX_CMD_EN
    task automatic test_cmd();
        logic [31:0] rx;
        logic [15:0] tx;
        int c0 = cv_seen;
        spi_xfer(16, 32'h2121, -1, 16'h0, 1'b1, rx);
        n_cmp++; if (cmd_word !== 16'h2121) begin n_bad++; $display("FAIL cmd_word: got %h want 2121", cmd_word); end
        n_cmp++; if (cv_seen - c0 !== 1) begin n_bad++; $display("FAIL cmd_valid: got %0d want 1", cv_seen - c0); end
        for (int k = 0; k < 3; k++) begin
            tx = 16'($urandom);
            spi_xfer(16, {16'h0, tx}, -1, 16'h0, 1'b1, rx);
            n_cmp++; if (cmd_word !== tx) begin n_bad++; $display("FAIL cmd_rand[%0d]: got %h want %h", k, cmd_word, tx); end
        end
        n_cmp++; if (cv_bad !== 0) begin n_bad++; $display("FAIL cmd_coincide: got %0d want 0", cv_bad); end
    endtask
`endif

    initial begin
        bus.spi_clk = 1'b0;
        bus.cs_n    = 1'b1;
        bus.mosi    = 1'b0;
        m_shadow    = '0;
        m_stale     = 1'b1;
        test_reset();
        test_no_load();
        test_load_basic();
        test_midframe_load();
        test_abort();
        test_overrun();
        test_random();
        test_reset_midframe();
`ifdef SPI_RESPOND_RX_CMD_EN
        test_cmd();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
